// File: rtl/gelato_ram_responder.sv
// gelato_ram_responder: in-order, fixed-latency word read responder for the
// instruction-fetch RAM protocol, with a preload write port into program memory.
// Requests read storage in the accept cycle, ride a short latency pipeline and
// land in a response FIFO. A credit counter bounds outstanding requests so the
// FIFO can never overflow and the pipeline never has to stall.
// Word width must be at least 16 bits so that a byte offset field exists.
module gelato_ram_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  resp_err,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_data
);

  localparam int BYTE_OFF = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = $clog2(MEM_WORDS);
  localparam int WORD_W   = ADDR_WIDTH - BYTE_OFF;
  localparam int PTR_W    = $clog2(2 * FIFO_DEPTH);
  localparam int FIDX_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  localparam logic [WORD_W-1:0] WORD_LIMIT = WORD_W'(MEM_WORDS);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(2 * FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_DEPTH  = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  // A byte address is usable when it is word aligned and inside storage.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    logic aligned;
    logic in_range;
    aligned  = (addr[BYTE_OFF-1:0] == {BYTE_OFF{1'b0}});
    in_range = (addr[ADDR_WIDTH-1:BYTE_OFF] < WORD_LIMIT);
    return aligned && in_range;
  endfunction

  // FIFO pointers carry one extra lap bit and wrap at 2*FIFO_DEPTH, so the
  // depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_ONE;
    end
    return nxt;
  endfunction

  function automatic logic [FIDX_W-1:0] ptr_idx(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] idx;
    if (ptr >= PTR_DEPTH) begin
      idx = ptr - PTR_DEPTH;
    end else begin
      idx = ptr;
    end
    return FIDX_W'(idx);
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];

  logic                  accept_s;
  logic                  pop_s;
  logic                  req_err_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  init_wr_s;

  logic                  push_valid_s;
  logic [DATA_WIDTH-1:0] push_data_s;
  logic [TAG_WIDTH-1:0]  push_tag_s;
  logic                  push_err_s;

  logic [DATA_WIDTH-1:0] fifo_data_r [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag_r  [FIFO_DEPTH];
  logic                  fifo_err_r  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [FIDX_W-1:0]     wr_idx_s;
  logic [FIDX_W-1:0]     rd_idx_s;
  logic                  fifo_has_s;
  logic [CNT_W-1:0]      cnt_r;

  // Credit check depends only on registered state, never on resp_ready.
  assign req_ready = rdy && !rst && (cnt_r < CNT_FULL);

  // Decode the request and read storage combinationally in the accept cycle,
  // so a same-cycle preload to that word is seen only by later reads.
  always_comb begin
    accept_s  = req_valid && req_ready && rdy;
    req_err_s = !addr_ok(req_addr);
    if (req_err_s) begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      rd_data_s = mem_r[req_addr[BYTE_OFF +: IDX_W]];
    end
    init_wr_s = rdy && init_we && addr_ok(init_addr);
  end

  // Preload port; bad addresses are dropped and reset leaves contents intact.
  always_ff @(posedge clk) begin
    if (init_wr_s) begin
      mem_r[init_addr[BYTE_OFF +: IDX_W]] <= init_data;
    end
  end

  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign push_valid_s = accept_s;
      assign push_data_s  = rd_data_s;
      assign push_tag_s   = req_tag;
      assign push_err_s   = req_err_s;
    end else begin : g_pipe
      logic                  pipe_valid_r [LATENCY-1];
      logic [DATA_WIDTH-1:0] pipe_data_r  [LATENCY-1];
      logic [TAG_WIDTH-1:0]  pipe_tag_r   [LATENCY-1];
      logic                  pipe_err_r   [LATENCY-1];

      // Latency pipeline: advances one stage per enabled cycle, frozen when rdy is low.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            pipe_valid_r[i] <= 1'b0;
            pipe_data_r[i]  <= {DATA_WIDTH{1'b0}};
            pipe_tag_r[i]   <= {TAG_WIDTH{1'b0}};
            pipe_err_r[i]   <= 1'b0;
          end
        end else if (rdy) begin
          pipe_valid_r[0] <= accept_s;
          pipe_data_r[0]  <= rd_data_s;
          pipe_tag_r[0]   <= req_tag;
          pipe_err_r[0]   <= req_err_s;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pipe_valid_r[i] <= pipe_valid_r[i-1];
            pipe_data_r[i]  <= pipe_data_r[i-1];
            pipe_tag_r[i]   <= pipe_tag_r[i-1];
            pipe_err_r[i]   <= pipe_err_r[i-1];
          end
        end
      end

      assign push_valid_s = pipe_valid_r[LATENCY-2];
      assign push_data_s  = pipe_data_r[LATENCY-2];
      assign push_tag_s   = pipe_tag_r[LATENCY-2];
      assign push_err_s   = pipe_err_r[LATENCY-2];
    end
  endgenerate

  assign wr_idx_s   = ptr_idx(wr_ptr_r);
  assign rd_idx_s   = ptr_idx(rd_ptr_r);
  assign fifo_has_s = (wr_ptr_r != rd_ptr_r);
  assign pop_s      = resp_valid && resp_ready && rdy;

  // Response FIFO storage: the pipeline tail is written at the write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
        fifo_tag_r[i]  <= {TAG_WIDTH{1'b0}};
        fifo_err_r[i]  <= 1'b0;
      end
    end else if (rdy && push_valid_s) begin
      fifo_data_r[wr_idx_s] <= push_data_s;
      fifo_tag_r[wr_idx_s]  <= push_tag_s;
      fifo_err_r[wr_idx_s]  <= push_err_s;
    end
  end

  // FIFO pointers and outstanding credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (rdy) begin
      if (push_valid_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Present the FIFO head; response fields read as zero when nothing is pending.
  always_comb begin
    resp_valid = fifo_has_s && !rst;
    if (resp_valid) begin
      resp_data = fifo_data_r[rd_idx_s];
      resp_tag  = fifo_tag_r[rd_idx_s];
      resp_err  = fifo_err_r[rd_idx_s];
    end else begin
      resp_data = {DATA_WIDTH{1'b0}};
      resp_tag  = {TAG_WIDTH{1'b0}};
      resp_err  = 1'b0;
    end
  end

endmodule

// File: doc/gelato_ram_responder.md
Name: gelato_ram_responder

Overview:
- Responder end of the instruction-fetch RAM protocol. The fetch unit issues word read requests; this block serves them from on-chip storage after a fixed latency, returning data in request order.
- Sits beside the core top level. It holds program memory that is preloaded through a write port before execution starts.
- Used both as the synthesizable instruction store and as the fetch-side memory model in simulation.

Parameters:
- ADDR_WIDTH, 32, byte address width of requests.
- DATA_WIDTH, 32, word width. Words are DATA_WIDTH/8 bytes.
- MEM_WORDS, 1024, storage depth in words. Power of two.
- LATENCY, 2, cycles from request acceptance to earliest response valid. Must be 1 or more.
- FIFO_DEPTH, 4, maximum outstanding requests (in pipeline plus queued). Must be LATENCY+1 or more.
- TAG_WIDTH, 4, width of the request tag, returned unchanged with the response.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable. When low, all state is frozen.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_WIDTH  byte address.
- req_tag  in  TAG_WIDTH  requester tag.
- resp_valid  out  1  response valid.
- resp_ready  in  1  requester accepts the response.
- resp_data  out  DATA_WIDTH  read word.
- resp_tag  out  TAG_WIDTH  tag of the originating request.
- resp_err  out  1  request was misaligned or out of range.
- init_we  in  1  preload write enable.
- init_addr  in  ADDR_WIDTH  preload byte address. Must be word aligned.
- init_data  in  DATA_WIDTH  preload data.

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high on rst.
- Reset state: req_ready=0 while rst=1. resp_valid=0, resp_data=0, resp_tag=0, resp_err=0. Outstanding counter=0, pipeline valid bits=0, FIFO read and write pointers=0.
- Reset does not clear memory contents.
- Request accept: occurs when req_valid && req_ready && rdy.
- req_ready = rdy && !rst && (outstanding < FIFO_DEPTH). It is registered-state based only, with no combinational path from resp_ready. A full counter with a same-cycle response pop still deasserts req_ready.
- Word index: word index = req_addr >> log2(DATA_WIDTH/8).
- Error conditions: misaligned (low address bits nonzero) or word index >= MEM_WORDS. The request is still accepted and occupies a slot. The response has resp_err=1 and resp_data=0.
- Memory read timing: storage is read in the accept cycle (pipeline stage 0).
- Same-cycle preload collision: if init_we writes the same word in the accept cycle, the old data is returned.
- Preload write: init_we with rdy=1 writes memory. Out-of-range or misaligned init writes are ignored.
- Latency pipeline: LATENCY-1 further register stages carry {valid, data, tag, err}. An entry accepted at cycle t enters the response FIFO at the end of cycle t+LATENCY-1. resp_valid can therefore first be seen in cycle t+LATENCY.
- Response FIFO: circular buffer of FIFO_DEPTH entries. The pointer is 1 bit wider than the index for full/empty detection and wraps modulo 2*FIFO_DEPTH.
- The credit limit guarantees the FIFO never overflows, so no pipeline stall is needed.
- Response outputs: resp_valid = FIFO not empty. resp_data, resp_tag and resp_err are driven from the FIFO head.
- Response transfer: occurs when resp_valid && resp_ready && rdy. While resp_valid=1 and no transfer happens, all resp_* outputs hold stable.
- Outstanding counter: +1 on accept, -1 on response transfer, unchanged if both occur in the same cycle. Range is 0..FIFO_DEPTH.
- Ordering: responses are returned strictly in acceptance order.
- rdy=0: no accept, no pipeline advance, no FIFO push or pop, no counter change, no init write. Outputs hold, except req_ready=0.
- Reset mid-operation: all in-flight and queued responses are discarded. No response from pre-reset requests appears afterwards.
- Throughput: one request and one response per cycle when resp_ready is held high.

Test Plan:
- Back-to-back streaming: preload word 0..7 = 0x1000+i. Issue addresses 0x0,0x4,...,0x1C with tags 0..7 on consecutive cycles, resp_ready=1. Expect resp_valid from cycle 2 after the first accept, then data 0x1000..0x1007 and tags 0..7 on consecutive cycles, resp_err=0, req_ready never drops.
- Backpressure/full: resp_ready=0 with 6 requests offered. Expect exactly 4 accepted, then req_ready=0 and resp_data held at 0x1000. Raise resp_ready and expect the remaining 2 accepted and all 6 responses returned in order.
- Error responses: request 0x2 and 0x1000 (word 1024). Expect two responses with resp_err=1 and resp_data=0, interleaved in order with neighbouring valid reads.
- Collision: in the accept cycle of address 0x8, init_we writes 0xDEAD to 0x8. Expect the response to be 0x1002. A later read of 0x8 returns 0xDEAD.
- rdy freeze: deassert rdy for 3 cycles with 2 requests in flight and resp_ready=1. Expect no outputs to change and no transfers. After rdy returns, the responses complete in order, with latency extended by 3 cycles.
- Mid-operation reset: assert rst for 1 cycle with 3 outstanding. Expect resp_valid=0 and req_ready=0 during reset, no stale responses afterwards, and preloaded memory still readable.
